// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Contents: FSM state enum, requester IDs, latency bound and counter widths.
// No ports; imported by rr_pick2, dmem_arbiter_if users and dmem_arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_RD_WAIT = 1'b1
   } arb_state_e;

   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

   localparam int MEM_LAT_MAX = 4;
   // Width of the read-latency down-counter; must hold MEM_LAT_MAX.
   localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);
   // Width of the per-requester grant counters.
   localparam int GNT_CNT_W   = 32;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester (m0/m1) and memory-port bundle of the arbiter.
// Ports: mN req/wren/addr/wdata/be in, mN gnt/rvld/rdata out, mem_* out, mem_rdata in.
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                i_m0_req;
   logic                i_m0_wren;
   logic [ADDR_W-1:0]   i_m0_addr;
   logic [DATA_W-1:0]   i_m0_wdata;
   logic [DATA_W/8-1:0] i_m0_be;
   logic                o_m0_gnt;
   logic                o_m0_rvld;
   logic [DATA_W-1:0]   o_m0_rdata;

   logic                i_m1_req;
   logic                i_m1_wren;
   logic [ADDR_W-1:0]   i_m1_addr;
   logic [DATA_W-1:0]   i_m1_wdata;
   logic [DATA_W/8-1:0] i_m1_be;
   logic                o_m1_gnt;
   logic                o_m1_rvld;
   logic [DATA_W-1:0]   o_m1_rdata;

   logic                o_mem_en;
   logic                o_mem_wren;
   logic [ADDR_W-1:0]   o_mem_addr;
   logic [DATA_W-1:0]   o_mem_wdata;
   logic [DATA_W/8-1:0] o_mem_be;
   logic [DATA_W-1:0]   i_mem_rdata;

   modport slave (
      input  i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_be,
      input  i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_be,
      input  i_mem_rdata,
      output o_m0_gnt, o_m0_rvld, o_m0_rdata,
      output o_m1_gnt, o_m1_rvld, o_m1_rdata,
      output o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_be
   );

   modport master (
      output i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_be,
      output i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_be,
      output i_mem_rdata,
      input  o_m0_gnt, o_m0_rvld, o_m0_rdata,
      input  o_m1_gnt, o_m1_rvld, o_m1_rdata,
      input  o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_be
   );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
// Ports: req[1:0] in, prio in (0 favours m0, 1 favours m1); gnt[1:0] one-hot out, id out.
// Zero latency; no state, the caller owns and updates prio.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt,
   output logic       id
);

   always_comb begin
      gnt = 2'b00;
      id  = ARB_M0;
      // m0 wins when it is the only requester or when it is favoured.
      if (req[0] && (!req[1] || (prio == ARB_M0))) begin
         gnt = 2'b01;
         id  = ARB_M0;
      end else if (req[1]) begin
         gnt = 2'b10;
         id  = ARB_M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory port between m0 and m1.
// Ports: i_clk, i_rst (sync, active-high), bus (dmem_arbiter_if.slave), o_mN_gnt_cnt.
// Writes complete in the grant cycle; a read holds the port MEM_LAT cycles and its
// data is passed through combinationally to the owner. Grant counters are built only
// when DMEM_ARB_PERF_CNT_EN is defined, otherwise tied to 0.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   dmem_arbiter_if.slave        bus,
   output logic [GNT_CNT_W-1:0] o_m0_gnt_cnt,
   output logic [GNT_CNT_W-1:0] o_m1_gnt_cnt
);

   arb_state_e          state;
   logic [CNT_W-1:0]    cnt;
   logic                owner;
   logic                prio;

   logic                rd_done;
   logic                port_free;
   logic [1:0]          req_vec;
   logic [1:0]          gnt;
   logic                win_id;
   logic                any_gnt;

   logic                sel_wren;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W/8-1:0] sel_be;

   // The last wait cycle both returns the data and frees the port, so a new
   // grant may coincide with rvld. Reset masks every combinational output.
   assign rd_done   = !i_rst && (state == ARB_RD_WAIT) && (cnt == CNT_W'(1));
   assign port_free = !i_rst && ((state == ARB_IDLE) || rd_done);
   assign req_vec   = {bus.i_m1_req, bus.i_m0_req} & {2{port_free}};

   rr_pick2 u_pick (
      .req  (req_vec),
      .prio (prio),
      .gnt  (gnt),
      .id   (win_id)
   );

   assign any_gnt = |gnt;

   always_comb begin
      sel_wren  = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      if (gnt[0]) begin
         sel_wren  = bus.i_m0_wren;
         sel_addr  = bus.i_m0_addr;
         sel_wdata = bus.i_m0_wdata;
         sel_be    = bus.i_m0_be;
      end else if (gnt[1]) begin
         sel_wren  = bus.i_m1_wren;
         sel_addr  = bus.i_m1_addr;
         sel_wdata = bus.i_m1_wdata;
         sel_be    = bus.i_m1_be;
      end
   end

   assign bus.o_m0_gnt    = gnt[0];
   assign bus.o_m1_gnt    = gnt[1];
   assign bus.o_mem_en    = any_gnt;
   assign bus.o_mem_wren  = sel_wren;
   assign bus.o_mem_addr  = sel_addr;
   assign bus.o_mem_wdata = sel_wdata;
   assign bus.o_mem_be    = sel_be;

   assign bus.o_m0_rvld  = rd_done && (owner == ARB_M0);
   assign bus.o_m1_rvld  = rd_done && (owner == ARB_M1);
   assign bus.o_m0_rdata = bus.o_m0_rvld ? bus.i_mem_rdata : '0;
   assign bus.o_m1_rdata = bus.o_m1_rvld ? bus.i_mem_rdata : '0;

   // FSM, latency counter, owner and priority. A grant in the rd_done cycle
   // overrides the return to idle when it is itself a read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ARB_IDLE;
         cnt   <= '0;
         owner <= ARB_M0;
         prio  <= ARB_M0;
      end else begin
         if (state == ARB_RD_WAIT) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state <= ARB_IDLE;
            end
         end
         if (any_gnt) begin
            prio <= ~win_id;
            if (!sel_wren) begin
               state <= ARB_RD_WAIT;
               owner <= win_id;
               cnt   <= CNT_W'(MEM_LAT);
            end
         end
      end
   end

`ifdef DMEM_ARB_PERF_CNT_EN
   logic [GNT_CNT_W-1:0] gnt_cnt0;
   logic [GNT_CNT_W-1:0] gnt_cnt1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else begin
         if (gnt[0]) gnt_cnt0 <= gnt_cnt0 + GNT_CNT_W'(1);
         if (gnt[1]) gnt_cnt1 <= gnt_cnt1 + GNT_CNT_W'(1);
      end
   end

   assign o_m0_gnt_cnt = gnt_cnt0;
   assign o_m1_gnt_cnt = gnt_cnt1;
`else
   assign o_m0_gnt_cnt = '0;
   assign o_m1_gnt_cnt = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing one data-memory port between the core's load/store path (m0) and a debug/DMA port (m1). Sits between the requesters and the data memory/IO bank; grants one transaction at a time, round-robin, and routes read data back to the owner after a fixed memory latency. Writes complete in their grant cycle. Reads hold the port until their data returns.

## Interface
- MEM_LAT, 1: cycles from read grant to valid `i_mem_rdata`; legal range 1..4.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte enables are DATA_W/8 wide.

Ports:
- i_clk  in  1  clock; rising edge. One clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_m0_req, i_m1_req  in  1  request; payload valid while high.
- i_mN_wren  in  1  1 = store, 0 = load.
- i_mN_addr  in  ADDR_W  byte address.
- i_mN_wdata  in  DATA_W  store data.
- i_mN_be  in  DATA_W/8  byte enables.
- o_mN_gnt  out  1  request accepted this cycle; combinational.
- o_mN_rvld  out  1  read data valid; one-cycle pulse.
- o_mN_rdata  out  DATA_W  read data; 0 when o_mN_rvld is low.
- o_mem_en  out  1  memory access this cycle.
- o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_be  out  —  forwarded payload of the granted requester.
- i_mem_rdata  in  DATA_W  memory read data.
- o_m0_gnt_cnt, o_m1_gnt_cnt  out  32  grant counters (see Configuration).

## Operation
States:
- ARB_IDLE: port free.
- ARB_RD_WAIT: read outstanding.

Priority:
- `prio` is one bit; 0 favours m0, 1 favours m1.
- Reset value of `prio` is 0.

ARB_IDLE behaviour:
- If any request is pending, grant one: the only requester, or the favoured one if both request.
- In the grant cycle, assert o_mN_gnt and o_mem_en, and forward that requester's payload to the mem port.
- After a grant to mX, `prio` favours the other requester.
- Write grant: the transaction completes and the state stays ARB_IDLE.
- Read grant: record owner, load `cnt` = MEM_LAT, go to ARB_RD_WAIT.

ARB_RD_WAIT behaviour:
- No grants while `cnt` > 1; `cnt` decrements each cycle.
- In the cycle `cnt` == 1 (i.e. grant cycle + MEM_LAT):
  - assert o_owner_rvld, with o_owner_rdata = i_mem_rdata (combinational pass-through);
  - return to ARB_IDLE;
  - the same cycle may issue a new grant by the ARB_IDLE rules (back-to-back).

Handshake rules:
- A requester holds req and payload stable until gnt.
- It may drop req before gnt (withdrawal); nothing is issued.
- After gnt, the next transaction needs req still high on a later cycle.

Mem-port outputs:
- When o_mem_en = 0, all o_mem_* are 0.
- Non-owner rdata is 0.

Reset: all outputs 0; state ARB_IDLE; `prio` 0; counters 0. Reset during ARB_RD_WAIT abandons the read and no rvld is ever produced for it.

## Timing
- Write: accepted in the cycle req is seen with the port free; 0 cycles of added latency.
- Read: gnt at T, rvld at T+MEM_LAT.
- Peak throughput:
  - writes: 1 per cycle;
  - reads: 1 per MEM_LAT cycles.
- Starvation bound: a continuously held request is granted within (MEM_LAT + 1) cycles after the other requester's grant.
- Same-cycle events:
  - both requesters asking: `prio` decides;
  - rvld and gnt together: both allowed;
  - i_rst has priority over everything.

## Configuration
- Macro: DMEM_ARB_PERF_CNT_EN.
- Defined: o_mN_gnt_cnt increments by 1 on each grant to mN; wraps 0xFFFFFFFF -> 0; cleared by i_rst.
- Undefined: the counter registers are not built and both ports are tied to 0. The port list is identical in both builds.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_e` {ARB_IDLE, ARB_RD_WAIT};
  - requester IDs ARB_M0 = 0, ARB_M1 = 1;
  - MEM_LAT_MAX = 4;
  - counter width.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs: req[1:0], prio. Outputs: one-hot gnt[1:0], winner id.
- The FSM, latency counter, owner register, payload mux and perf counters live in dmem_arbiter.

## Test plan
- Reset, then m0 store addr 0x100 data 0xDEADBEEF be 0xF: o_m0_gnt and o_mem_en high in the same cycle; mem sees the payload; state stays IDLE; gnt_cnt0 = 1 with the macro, 0 without.
- MEM_LAT = 2, m1 load 0x200 (mem returns 0x12345678): gnt at T, o_m1_rvld = 1 with rdata 0x12345678 at T+2; o_m0_rvld = 0 throughout.
- Both requesters hold stores for 6 cycles: grants alternate m0, m1, m0, m1, m0, m1.
- MEM_LAT = 3, m0 read at T with m1 store pending: m1 gnt only at T+3, coinciding with o_m0_rvld.
- i_rst asserted at T+1 of a MEM_LAT = 3 read: no rvld at T+3; all outputs 0; next simultaneous request grants m0.
- m1 drops req before a grant while m0 holds the port in ARB_RD_WAIT: no m1 grant and no mem access on its behalf.
